// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle for muldiv_unit, including the flush line.
interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flash;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_opa;
  logic [XLEN-1:0]  in_opb;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport slave (
    input  flash, in_valid, in_funct3, in_opa, in_opb, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );

  modport master (
    output flash, in_valid, in_funct3, in_opa, in_opb, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// sign handled on magnitudes with a final fixup edge.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  muldiv_unit_if.slave    bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_f3;
  logic [TAG_W-1:0]  r_tag, r_out_tag;
  logic              r_neg;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_a, r_b, r_result;
  logic [XLEN:0]     r_hi;

  logic              w_accept, w_sa, w_sb, w_div0, w_ovf, w_special;
  logic [2:0]        w_f;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [XLEN:0]     w_sum, w_rsh, w_diff, w_mul_hi, w_div_hi;
  logic [XLEN-1:0]   w_mul_lo, w_div_lo, w_quo, w_rem, w_fix;
  logic [2*XLEN-1:0] w_prod;

  assign w_f      = bus.in_funct3;
  assign w_accept = bus.in_valid & (r_state == S_IDLE) & ~bus.flash;
  assign w_sa     = ~(w_f[0] & (w_f[1] | w_f[2])) & bus.in_opa[XLEN-1];
  assign w_sb     = ~((w_f[1] & ~w_f[2]) | (w_f[0] & w_f[2])) & bus.in_opb[XLEN-1];
  assign w_mag_a  = w_sa ? -bus.in_opa : bus.in_opa;
  assign w_mag_b  = w_sb ? -bus.in_opb : bus.in_opb;
  assign w_div0   = w_f[2] & (bus.in_opb == '0);
  assign w_ovf    = w_f[2] & ~w_f[0] & (bus.in_opa == {1'b1, {(XLEN-1){1'b0}}})
                    & (bus.in_opb == '1);
  assign w_special = w_div0 | w_ovf;

  // Multiply step: {r_hi, r_b} shifts right, r_b[0] is the current multiplier bit
  assign w_sum    = r_b[0] ? r_hi + {1'b0, r_a} : r_hi;
  assign w_mul_hi = {1'b0, w_sum[XLEN:1]};
  assign w_mul_lo = {w_sum[0], r_b[XLEN-1:1]};

  // Divide step: {r_hi, r_b} shifts left, quotient bits enter at r_b[0]
  assign w_rsh    = {r_hi[XLEN-1:0], r_b[XLEN-1]};
  assign w_diff   = w_rsh - {1'b0, r_a};
  assign w_div_hi = w_diff[XLEN] ? w_rsh : w_diff;
  assign w_div_lo = {r_b[XLEN-2:0], ~w_diff[XLEN]};

  assign w_prod = r_neg ? -{r_hi[XLEN-1:0], r_b} : {r_hi[XLEN-1:0], r_b};
  assign w_quo  = r_neg ? -r_b : r_b;
  assign w_rem  = r_neg ? -r_hi[XLEN-1:0] : r_hi[XLEN-1:0];

  always_comb begin
    w_fix = w_prod[2*XLEN-1:XLEN];
    if (r_f3[2])            w_fix = r_f3[1] ? w_rem : w_quo;
    else if (r_f3 == 3'b000) w_fix = w_prod[XLEN-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  if (bus.flash) w_next = S_IDLE;
               else if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  if (bus.flash | bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Special divides preload their answer into {r_hi, r_b} and enter CALC with a
  // zero count, so the single fixup edge lands them in DONE one edge after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_f3      <= '0;
      r_tag     <= '0;
      r_out_tag <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_f3  <= w_f;
        r_tag <= bus.in_tag;
        r_a   <= w_f[2] ? w_mag_b : w_mag_a;
        r_neg <= w_special ? 1'b0 : ((w_f[2] & w_f[1]) ? w_sa : (w_sa ^ w_sb));
        r_cnt <= w_special ? '0 : CW'(XLEN);
        r_b   <= w_div0 ? '1 : (w_ovf ? bus.in_opa : (w_f[2] ? w_mag_a : w_mag_b));
        r_hi  <= w_div0 ? {1'b0, bus.in_opa} : '0;
      end else if (r_state == S_CALC && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
        r_hi  <= r_f3[2] ? w_div_hi : w_mul_hi;
        r_b   <= r_f3[2] ? w_div_lo : w_mul_lo;
      end else if (r_state == S_CALC && !bus.flash) begin
        r_result  <= w_fix;
        r_out_tag <= r_tag;
      end
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.out_result = r_result;
  assign bus.out_tag    = r_out_tag;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random RV32M checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ref_op = '0;
    case (f)
      3'd0: begin p = sa * sb; ref_op = p[31:0];  end
      3'd1: begin p = sa * sb; ref_op = p[63:32]; end
      3'd2: begin p = sa * ub; ref_op = p[63:32]; end
      3'd3: begin p = ua * ub; ref_op = p[63:32]; end
      3'd4: begin
        if (b == 0) ref_op = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = a;
        else begin q = $signed(a) / $signed(b); ref_op = q; end
      end
      3'd5: ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_op = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = '0;
        else begin q = $signed(a) % $signed(b); ref_op = q; end
      end
      default: ref_op = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Issue one op, measure latency, optionally hold off out_ready for `hold` cycles.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({nm, ".in_ready_pre"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f;
    bus.in_opa    = a;
    bus.in_opb    = b;
    bus.in_tag    = tag;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({nm, ".busy"}, bus.busy, 1);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, ".valid"}, bus.out_valid, 1);
    check({nm, ".latency"}, lat, exp_lat);
    check({nm, ".result"}, bus.out_result, exp);
    check({nm, ".tag"}, bus.out_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, ".hold_valid"}, bus.out_valid, 1);
      check({nm, ".hold_result"}, bus.out_result, exp);
      check({nm, ".hold_tag"}, bus.out_tag, tag);
      check({nm, ".hold_in_ready"}, bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, ".in_ready_post"}, bus.in_ready, 1);
    check({nm, ".valid_post"}, bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  t;
    int          seen;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    bus.flash = 1'b0; bus.in_valid = 1'b0; bus.in_funct3 = '0;
    bus.in_opa = '0; bus.in_opb = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    #12;
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.result", bus.out_result, 0);
    check("rst.tag", bus.out_tag, 0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'h15, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'h01, 32'h4000_0000, 33, 0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 32'hFFFF_FFFF, 33, 0);
    run_op("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'h0000_0001, 33, 0);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'h05, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'h06, 32'hFFFF_FFFF, 33, 0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'h07, 32'd14, 33, 0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'h08, 32'd2, 33, 0);
    run_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'h09, 32'd1, 33, 0);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 5'h0A, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'h0B, 32'd5, 1, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0C, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0D, 32'd0, 1, 0);
    run_op("backpressure", 3'd0, 32'd1234, 32'd5678, 5'h1E, 32'd7006652, 33, 5);

    // Flush in IDLE must block acceptance
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flash = 1'b1; bus.in_funct3 = 3'd0;
    @(posedge clk); #1;
    check("flash_idle.busy", bus.busy, 0);
    check("flash_idle.in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0; bus.flash = 1'b0;

    // Flush mid-calculation
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_funct3 = 3'd0; bus.in_opa = 32'd3; bus.in_opb = 32'd4;
    bus.in_tag = 5'h11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flash = 1'b1;
    @(posedge clk); #1;
    bus.flash = 1'b0;
    check("flash_calc.in_ready", bus.in_ready, 1);
    check("flash_calc.out_valid", bus.out_valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("flash_calc.no_result", seen, 0);
    run_op("after_flash_divu", 3'd5, 32'd9, 32'd3, 5'h12, 32'd3, 33, 0);

    // Randomized ops against the reference
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      t = 5'($urandom);
      run_op($sformatf("rand%0d_f%0d_%h_%h", n, f, a, b), f, a, b, t,
             ref_op(f, a, b), ref_lat(f, a, b), n % 3);
    end

    // Asynchronous reset mid-calculation
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_funct3 = 3'd5; bus.in_opa = 32'd77; bus.in_opb = 32'd5;
    bus.in_tag = 5'h1F;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst.in_ready", bus.in_ready, 1);
    check("arst.out_valid", bus.out_valid, 0);
    check("arst.busy", bus.busy, 0);
    check("arst.result", bus.out_result, 0);
    check("arst.tag", bus.out_tag, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst_mulhu", 3'd3, 32'h0001_0000, 32'h0003_0000, 5'h13, 32'd3, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
